// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag field layout, line geometry and responder states.
package sysbus_pkg;

  localparam int TAG_RD_BIT     = 12;
  localparam int TAG_TYPE_MSB   = 11;
  localparam int TAG_TYPE_LSB   = 8;
  localparam int BEATS_PER_LINE = 8;
  localparam int LINE_OFF_W     = 3;

  localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LAT      = 2'd1;
  localparam logic [1:0] ST_RD_BURST = 2'd2;
  localparam logic [1:0] ST_WR_DATA  = 2'd3;

  function automatic logic tag_is_read(input logic [12:0] tag);
    return tag[TAG_RD_BIT];
  endfunction

endpackage

// File: rtl/sysbus_mem_array.sv
// Backing store for the Sysbus responder: one synchronous write port, one
// asynchronous read port.
module sysbus_mem_array #(
  parameter int    DATA_W    = 64,
  parameter int    WORDS     = 65536,
  parameter int    AW        = $clog2(WORDS),
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: accepts line requests and returns 8 wrapped beats.
// Define SYSBUS_RESP_WRITE_EN to store 8-beat line writes; otherwise they are acked and dropped.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int    BUS_DATA_WIDTH = 64,
  parameter int    BUS_TAG_WIDTH  = 13,
  parameter int    MEM_WORDS      = 65536,
  parameter int    RESP_LATENCY   = 4,
  parameter string INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int AW     = $clog2(MEM_WORDS);
  localparam int LINE_W = AW - LINE_OFF_W;
  localparam int LAT_W  = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RESP_LATENCY - 1);

`ifdef SYSBUS_RESP_WRITE_EN
  localparam logic WR_EN = 1'b1;
`else
  localparam logic WR_EN = 1'b0;
`endif

  logic [1:0]                state_q, state_d;
  logic [LINE_OFF_W-1:0]     beat_q, beat_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [LINE_OFF_W-1:0]     start_q, start_d;

  logic [LINE_OFF_W-1:0]     word_off;
  logic [AW-1:0]             mem_addr;
  logic                      mem_we;
  logic [BUS_DATA_WIDTH-1:0] rd_data;

  // Critical word first: the beat counter offsets the start word, wrapping within the line.
  assign word_off = start_q + beat_q;
  assign mem_addr = {line_q, word_off};

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    tag_d       = tag_q;
    line_d      = line_q;
    start_d     = start_q;
    mem_we      = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus_reqack = bus_reqcyc;
        if (bus_reqcyc) begin
          tag_d   = bus_reqtag;
          line_d  = bus_req[AW+2:LINE_OFF_W+3];
          start_d = bus_req[5:3];
          beat_d  = '0;
          lat_d   = LAT_LOAD;
          if (!tag_is_read(bus_reqtag)) state_d = ST_WR_DATA;
          else if (RESP_LATENCY == 1)   state_d = ST_RD_BURST;
          else                          state_d = ST_LAT;
        end
      end
      ST_LAT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LAT_W'(1)) state_d = ST_RD_BURST;
      end
      ST_RD_BURST: begin
        bus_respcyc = 1'b1;
        if (bus_respack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LINE_OFF_W'(BEATS_PER_LINE - 1)) state_d = ST_IDLE;
        end
      end
      default: begin
        bus_reqack = bus_reqcyc;
        if (bus_reqcyc) begin
          mem_we = WR_EN;
          beat_d = beat_q + 1'b1;
          if (beat_q == LINE_OFF_W'(BEATS_PER_LINE - 1)) state_d = ST_IDLE;
        end
      end
    endcase
    bus_resp    = bus_respcyc ? rd_data : '0;
    bus_resptag = bus_respcyc ? tag_q : '0;
  end

  // Control registers: state and counters carry the reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  // Request capture registers: only read while the outputs are gated by state.
  always_ff @(posedge clk) begin
    tag_q   <= tag_d;
    line_q  <= line_d;
    start_q <= start_d;
  end

  sysbus_mem_array #(
    .DATA_W    (BUS_DATA_WIDTH),
    .WORDS     (MEM_WORDS),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_addr),
    .wdata (bus_req),
    .raddr (mem_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: reads, wrap, backpressure, writes, reset.
module tb_sysbus_mem_responder;
  import sysbus_pkg::*;

  localparam int LAT = 4;
  localparam logic [12:0] RD_TAG  = {1'b1, SYSBUS_MEMORY, 8'h00};
  localparam logic [12:0] RD_TAG2 = {1'b1, SYSBUS_MEMORY, 8'h5A};
  localparam logic [12:0] WR_TAG  = {1'b0, SYSBUS_MEMORY, 8'h00};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_reqcyc = 1'b0;
  logic [63:0] bus_req = '0;
  logic [12:0] bus_reqtag = '0;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_v [8];

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .MEM_WORDS      (65536),
    .RESP_LATENCY   (LAT),
    .INIT_FILE      ("")
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", nm, obs, exp);
    end
  endtask

  // Called at a negedge. ack_dly: extra low-ack cycles per beat; pend_at: beat at which
  // a competing request is raised (-1 none); rst_at: beat at which reset is pulsed (-1 none).
  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                         input int ack_dly, input int pend_at, input int rst_at);
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
    #1 chk("rd_accept_ack", 64'(bus_reqack), 64'd1);
    @(posedge clk); #1;
    bus_reqcyc  = 1'b0;
    bus_respack = (ack_dly == 0);
    for (int c = 1; c < LAT; c++) begin
      @(negedge clk);
      chk("rd_latency_idle", 64'(bus_respcyc), 64'd0);
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("rd_valid", 64'(bus_respcyc), 64'd1);
      chk("rd_data", bus_resp, exp_v[n]);
      chk("rd_tag", 64'(bus_resptag), 64'(tag));
      if (pend_at >= 0 && n >= pend_at) begin
        if (n == pend_at) begin
          bus_reqcyc = 1'b1; bus_req = 64'h40; bus_reqtag = RD_TAG;
          #1;
        end
        chk("pend_no_ack", 64'(bus_reqack), 64'd0);
      end
      if (n == rst_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
        chk("rst_resp", bus_resp, 64'd0);
        chk("rst_resptag", 64'(bus_resptag), 64'd0);
        chk("rst_reqack", 64'(bus_reqack), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_respack = 1'b0;
        return;
      end
      if (ack_dly > 0) begin
        for (int w = 0; w < ack_dly; w++) begin
          @(negedge clk);
          chk("bp_valid_hold", 64'(bus_respcyc), 64'd1);
          chk("bp_data_hold", bus_resp, exp_v[n]);
        end
        bus_respack = 1'b1;
        @(posedge clk); #1;
        bus_respack = 1'b0;
      end
    end
    @(negedge clk);
    chk("rd_end_valid_low", 64'(bus_respcyc), 64'd0);
    if (pend_at >= 0) begin
      chk("pend_ack_after_burst", 64'(bus_reqack), 64'd1);
      bus_reqcyc = 1'b0;
    end
    bus_respack = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] base);
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = WR_TAG;
    #1 chk("wr_req_ack", 64'(bus_reqack), 64'd1);
    @(posedge clk); #1;
    for (int n = 0; n < 8; n++) begin
      bus_req = base + 64'(n);
      #1 chk("wr_beat_ack", 64'(bus_reqack), 64'd1);
      chk("wr_no_resp", 64'(bus_respcyc), 64'd0);
      @(posedge clk); #1;
    end
    bus_reqcyc = 1'b0;
    #1 chk("wr_idle_no_ack", 64'(bus_reqack), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) dut.u_mem.mem[k] <= 64'(k);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_reqack", 64'(bus_reqack), 64'd0);
    chk("reset_respcyc", 64'(bus_respcyc), 64'd0);
    chk("reset_resp", bus_resp, 64'd0);
    chk("reset_resptag", 64'(bus_resptag), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Aligned read, ack held high
    exp_v = '{64'd8, 64'd9, 64'd10, 64'd11, 64'd12, 64'd13, 64'd14, 64'd15};
    do_read(64'h40, RD_TAG, 0, -1, -1);

    // Wrapped read issued back-to-back, byte offset bits set
    exp_v = '{64'd13, 64'd14, 64'd15, 64'd8, 64'd9, 64'd10, 64'd11, 64'd12};
    do_read(64'h6F, RD_TAG2, 0, -1, -1);

    // Address beyond the array wraps to word 13
    do_read(64'h80068, RD_TAG, 0, -1, -1);

    // Backpressure on every beat
    exp_v = '{64'd24, 64'd25, 64'd26, 64'd27, 64'd28, 64'd29, 64'd30, 64'd31};
    do_read(64'hC0, RD_TAG, 3, -1, -1);

    // Write line then read it back
    do_write(64'h80, 64'hA0);
`ifdef SYSBUS_RESP_WRITE_EN
    exp_v = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7};
`else
    exp_v = '{64'd16, 64'd17, 64'd18, 64'd19, 64'd20, 64'd21, 64'd22, 64'd23};
`endif
    do_read(64'h80, RD_TAG, 0, -1, -1);

    // Competing request raised during a burst
    exp_v = '{64'd32, 64'd33, 64'd34, 64'd35, 64'd36, 64'd37, 64'd38, 64'd39};
    do_read(64'h100, RD_TAG, 0, 2, -1);
    @(negedge clk);

    // Async reset at beat 3, then memory still intact
    exp_v = '{64'd8, 64'd9, 64'd10, 64'd11, 64'd12, 64'd13, 64'd14, 64'd15};
    do_read(64'h40, RD_TAG, 0, -1, 3);
    @(negedge clk);
    do_read(64'h40, RD_TAG, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
